fxp_divider_pipe_hs: RTL and testbench



---
 rtl/fxp_divider_pipe_hs.sv | 223 ++++++++++++++++++++++
 tb/tb_fxp_divider_pipe_hs.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fxp_divider_pipe_hs.sv
// ---------------------------------------------------------------------------
// fxp_divider_pipe_hs
// Signed fixed-point restoring divider. It produces one quotient bit per
// clock and has valid/ready handshakes on both the operand and result sides.
// Operands and the result are two's complement Q(D_W-FRAC_W).FRAC_W.
// ROUND selects truncation toward zero (0) or round half away from zero (1).
// Results that do not fit saturate and raise O_OVF. A zero divisor raises
// O_DZ and returns the saturated value that has the dividend's sign.
//
// Ports:
//   I_CLK       clock, rising edge
//   I_RST       asynchronous active-high reset
//   I_VLD       operands valid
//   O_RDY       block can accept operands (IDLE only)
//   I_DIVIDEND  dividend, D_W bits
//   I_DIVISOR   divisor, D_W bits
//   O_VLD       result valid (held until I_RDY)
//   I_RDY       downstream accepts the result
//   O_QUOTIENT  quotient, D_W bits
//   O_OVF       result saturated, qualified by O_VLD
//   O_DZ        divisor was zero, qualified by O_VLD
// ---------------------------------------------------------------------------
module fxp_divider_pipe_hs #(
    parameter int D_W    = 16,
    parameter int FRAC_W = 13,
    parameter int ROUND  = 0
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_VLD,
    output logic           O_RDY,
    input  logic [D_W-1:0] I_DIVIDEND,
    input  logic [D_W-1:0] I_DIVISOR,
    output logic           O_VLD,
    input  logic           I_RDY,
    output logic [D_W-1:0] O_QUOTIENT,
    output logic           O_OVF,
    output logic           O_DZ
);

    // One extra quotient bit is computed when rounding, so it can be folded in.
    localparam int N     = D_W + FRAC_W + ROUND;
    localparam int SH    = FRAC_W + ROUND;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [D_W-1:0] MAX_Q   = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0] MIN_Q   = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [N:0]     NEG_LIM = {{(N+1-D_W){1'b0}}, 1'b1, {(D_W-1){1'b0}}};
    localparam logic [N:0]     POS_LIM = NEG_LIM - {{N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic             sign_r;
    logic             dz_r;
    logic             dvd_neg_r;
    logic [N-1:0]     dvd_sh_r;
    logic [D_W-1:0]   dvs_r;
    logic [D_W:0]     rem_r;
    logic [N-1:0]     q_r;
    logic [CNT_W-1:0] k_r;
    logic             rdy_r;
    logic             vld_r;
    logic [D_W-1:0]   quo_r;
    logic             ovf_r;
    logic             dzo_r;

    logic [D_W-1:0]   abs_dvd_s;
    logic [D_W-1:0]   abs_dvs_s;
    logic [N-1:0]     dvd_load_s;
    logic [D_W:0]     rem_sh_s;
    logic             ge_s;
    logic [D_W:0]     rem_nxt_s;
    logic [N-1:0]     q_nxt_s;
    logic [N-1:0]     m_s;
    logic [D_W-1:0]   res_s;
    logic             ovf_s;

    // Operand magnitudes and the dividend pre-shifted for bit-serial feeding.
    always_comb begin
        abs_dvd_s  = I_DIVIDEND;
        abs_dvs_s  = I_DIVISOR;
        dvd_load_s = {N{1'b0}};
        if (I_DIVIDEND[D_W-1]) begin
            abs_dvd_s = ~I_DIVIDEND + {{(D_W-1){1'b0}}, 1'b1};
        end else begin
            abs_dvd_s = I_DIVIDEND;
        end
        if (I_DIVISOR[D_W-1]) begin
            abs_dvs_s = ~I_DIVISOR + {{(D_W-1){1'b0}}, 1'b1};
        end else begin
            abs_dvs_s = I_DIVISOR;
        end
        dvd_load_s = N'(abs_dvd_s) << SH;
    end

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    always_comb begin
        rem_sh_s  = {rem_r[D_W-1:0], dvd_sh_r[N-1]};
        ge_s      = (rem_sh_s >= {1'b0, dvs_r});
        rem_nxt_s = rem_sh_s;
        if (ge_s) begin
            rem_nxt_s = rem_sh_s - {1'b0, dvs_r};
        end else begin
            rem_nxt_s = rem_sh_s;
        end
        q_nxt_s = {q_r[N-2:0], ge_s};
    end

    // Final magnitude, rounding, saturation and sign application for the last step.
    always_comb begin
        m_s   = q_nxt_s;
        res_s = {D_W{1'b0}};
        ovf_s = 1'b0;
        if (ROUND != 0) begin
            // The extra low bit is the half-LSB, so adding it rounds half away from zero.
            m_s = (q_nxt_s >> 1) + {{(N-1){1'b0}}, q_nxt_s[0]};
        end else begin
            m_s = q_nxt_s;
        end
        if (sign_r) begin
            if ({1'b0, m_s} > NEG_LIM) begin
                res_s = MIN_Q;
                ovf_s = 1'b1;
            end else begin
                // A zero magnitude negates to zero, so -0 cannot appear.
                res_s = ~m_s[D_W-1:0] + {{(D_W-1){1'b0}}, 1'b1};
                ovf_s = 1'b0;
            end
        end else begin
            if ({1'b0, m_s} > POS_LIM) begin
                res_s = MAX_Q;
                ovf_s = 1'b1;
            end else begin
                res_s = m_s[D_W-1:0];
                ovf_s = 1'b0;
            end
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_r   <= IDLE;
            sign_r    <= 1'b0;
            dz_r      <= 1'b0;
            dvd_neg_r <= 1'b0;
            dvd_sh_r  <= {N{1'b0}};
            dvs_r     <= {D_W{1'b0}};
            rem_r     <= {(D_W+1){1'b0}};
            q_r       <= {N{1'b0}};
            k_r       <= {CNT_W{1'b0}};
            rdy_r     <= 1'b0;
            vld_r     <= 1'b0;
            quo_r     <= {D_W{1'b0}};
            ovf_r     <= 1'b0;
            dzo_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy_r <= 1'b1;
                    if (I_VLD && rdy_r) begin
                        sign_r    <= I_DIVIDEND[D_W-1] ^ I_DIVISOR[D_W-1];
                        dvd_neg_r <= I_DIVIDEND[D_W-1];
                        dz_r      <= (abs_dvs_s == {D_W{1'b0}});
                        dvs_r     <= abs_dvs_s;
                        dvd_sh_r  <= dvd_load_s;
                        rem_r     <= {(D_W+1){1'b0}};
                        q_r       <= {N{1'b0}};
                        k_r       <= CNT_W'(N - 1);
                        rdy_r     <= 1'b0;
                        state_r   <= CALC;
                    end
                end
                CALC: begin
                    if (dz_r) begin
                        // Divide by zero skips iteration and leaves after a single cycle.
                        quo_r   <= dvd_neg_r ? MIN_Q : MAX_Q;
                        ovf_r   <= 1'b0;
                        dzo_r   <= 1'b1;
                        vld_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        rem_r    <= rem_nxt_s;
                        q_r      <= q_nxt_s;
                        dvd_sh_r <= dvd_sh_r << 1;
                        k_r      <= k_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (k_r == {CNT_W{1'b0}}) begin
                            quo_r   <= res_s;
                            ovf_r   <= ovf_s;
                            dzo_r   <= 1'b0;
                            vld_r   <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (I_RDY) begin
                        vld_r   <= 1'b0;
                        rdy_r   <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    vld_r   <= 1'b0;
                    rdy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign O_RDY      = rdy_r;
    assign O_VLD      = vld_r;
    assign O_QUOTIENT = quo_r;
    assign O_OVF      = ovf_r;
    assign O_DZ       = dzo_r;

endmodule

// File: tb/tb_fxp_divider_pipe_hs.sv
module tb_fxp_divider_pipe_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in [2];
    logic        rdy_in [2];
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic        rdy_o  [2];
    logic        vld_o  [2];
    logic        ovf_o  [2];
    logic        dz_o   [2];
    logic [15:0] quo_o  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fxp_divider_pipe_hs #(.D_W(16), .FRAC_W(13), .ROUND(0)) dut0 (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld_in[0]), .O_RDY(rdy_o[0]),
        .I_DIVIDEND(dvd), .I_DIVISOR(dvs), .O_VLD(vld_o[0]), .I_RDY(rdy_in[0]),
        .O_QUOTIENT(quo_o[0]), .O_OVF(ovf_o[0]), .O_DZ(dz_o[0])
    );

    fxp_divider_pipe_hs #(.D_W(16), .FRAC_W(13), .ROUND(1)) dut1 (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld_in[1]), .O_RDY(rdy_o[1]),
        .I_DIVIDEND(dvd), .I_DIVISOR(dvs), .O_VLD(vld_o[1]), .I_RDY(rdy_in[1]),
        .O_QUOTIENT(quo_o[1]), .O_OVF(ovf_o[1]), .O_DZ(dz_o[1])
    );

    typedef struct {
        int          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for O_RDY, then present operands for one accept edge.
    task automatic accept(input int s, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (rdy_o[s] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_before_accept", {31'd0, rdy_o[s]}, 32'd1);
        dvd = a;
        dvs = b;
        vld_in[s] = 1'b1;
        @(posedge clk); #1;
        vld_in[s] = 1'b0;
    endtask

    // Count edges from the accept edge (inclusive) until O_VLD is seen.
    task automatic wait_done(input int s, output int lat, output logic rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (vld_o[s] !== 1'b1 && lat < 200) begin
            if (rdy_o[s] !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result(input int s);
        rdy_in[s] = 1'b1;
        @(posedge clk); #1;
        rdy_in[s] = 1'b0;
    endtask

    initial begin
        int   lat;
        logic rseen;

        vecs[0]  = '{0, 16'h2000, 16'h1000, 16'h4000, 1'b0, 1'b0, 30};
        vecs[1]  = '{0, 16'hD000, 16'h1000, 16'hA000, 1'b0, 1'b0, 30};
        vecs[2]  = '{0, 16'h8000, 16'h2000, 16'h8000, 1'b0, 1'b0, 30};
        vecs[3]  = '{0, 16'h8000, 16'hE000, 16'h7FFF, 1'b1, 1'b0, 30};
        vecs[4]  = '{0, 16'h6000, 16'h0800, 16'h7FFF, 1'b1, 1'b0, 30};
        vecs[5]  = '{0, 16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0, 30};
        vecs[6]  = '{0, 16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0, 30};
        vecs[7]  = '{1, 16'h2000, 16'h6000, 16'h0AAB, 1'b0, 1'b0, 31};
        vecs[8]  = '{1, 16'hE000, 16'h6000, 16'hF555, 1'b0, 1'b0, 31};
        vecs[9]  = '{0, 16'hE000, 16'h0000, 16'h8000, 1'b0, 1'b1, 2};
        vecs[10] = '{0, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 2};
        vecs[11] = '{0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 30};
        vecs[12] = '{0, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, 30};
        vecs[13] = '{0, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 30};
        vecs[14] = '{0, 16'h8000, 16'h8000, 16'h2000, 1'b0, 1'b0, 30};
        vecs[15] = '{1, 16'h2000, 16'h1000, 16'h4000, 1'b0, 1'b0, 31};
        vecs[16] = '{1, 16'h6000, 16'h0800, 16'h7FFF, 1'b1, 1'b0, 31};

        rst = 1'b1;
        vld_in[0] = 1'b0; vld_in[1] = 1'b0;
        rdy_in[0] = 1'b0; rdy_in[1] = 1'b0;
        dvd = 16'h0000; dvs = 16'h0000;

        // Reset state
        #12;
        chk("rst_quo", {16'd0, quo_o[0]}, 32'd0);
        chk("rst_vld", {31'd0, vld_o[0]}, 32'd0);
        chk("rst_rdy", {31'd0, rdy_o[0]}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o[0]}, 32'd0);
        chk("rst_dz",  {31'd0, dz_o[0]},  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", {31'd0, rdy_o[0]}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            accept(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].s, lat, rseen);
            chk($sformatf("v%0d_quo", i), {16'd0, quo_o[vecs[i].s]}, {16'd0, vecs[i].q});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf_o[vecs[i].s]}, {31'd0, vecs[i].ovf});
            chk($sformatf("v%0d_dz", i),  {31'd0, dz_o[vecs[i].s]},  {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rdy_low", i), {31'd0, rseen}, 32'd0);
            release_result(vecs[i].s);
        end

        // Backpressure: result held for 10 cycles while new operands are offered
        accept(0, 16'h3000, 16'h2000);
        wait_done(0, lat, rseen);
        chk("bp_first", {16'd0, quo_o[0]}, 32'h3000);
        dvd = 16'h1000;
        dvs = 16'h2000;
        vld_in[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", {31'd0, vld_o[0]}, 32'd1);
            chk("bp_quo", {16'd0, quo_o[0]}, 32'h3000);
            chk("bp_rdy", {31'd0, rdy_o[0]}, 32'd0);
        end
        rdy_in[0] = 1'b1;
        @(posedge clk); #1;
        rdy_in[0] = 1'b0;
        chk("bp_vld_drop", {31'd0, vld_o[0]}, 32'd0);
        chk("bp_rdy_back", {31'd0, rdy_o[0]}, 32'd1);
        // I_VLD still high: this edge accepts the waiting operands
        @(posedge clk); #1;
        vld_in[0] = 1'b0;
        chk("bp_accepted", {31'd0, rdy_o[0]}, 32'd0);
        wait_done(0, lat, rseen);
        chk("bp_next_quo", {16'd0, quo_o[0]}, 32'h1000);
        chk("bp_next_lat", lat, 30);
        release_result(0);

        // Asynchronous reset in the middle of a division (k == 10)
        accept(0, 16'h1800, 16'h1000);
        repeat (18) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_quo", {16'd0, quo_o[0]}, 32'd0);
        chk("mid_rst_vld", {31'd0, vld_o[0]}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rdy_o[0]}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf_o[0]}, 32'd0);
        chk("mid_rst_dz",  {31'd0, dz_o[0]},  32'd0);
        @(posedge clk); #1;
        chk("mid_rst_rdy_hold", {31'd0, rdy_o[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rdy_rel", {31'd0, rdy_o[0]}, 32'd1);
        accept(0, 16'h2000, 16'h1000);
        wait_done(0, lat, rseen);
        chk("post_rst_quo", {16'd0, quo_o[0]}, 32'h4000);
        chk("post_rst_lat", lat, 30);
        chk("post_rst_ovf", {31'd0, ovf_o[0]}, 32'd0);
        chk("post_rst_dz",  {31'd0, dz_o[0]},  32'd0);
        release_result(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
